// File: rtl/memcpy_burst_sequencer.sv
// Splits one memcpy job into paired read/write bursts of 64-byte lines and bounds the writes in flight.
// Define MEMCPY_4K_BOUNDARY_EN to keep every burst inside one 4 KiB page on both addresses.
//
// state | meaning
// IDLE  | waiting for memcpy_enable; job inputs latched on exit
// CALC  | register the next burst length
// RD    | read command presented
// WR    | paired write command presented
// HOLD  | write window full, wait for a completion
// DRAIN | no more bursts, wait for outstanding writes to finish
// DONE  | job complete, wait for enable to drop
module memcpy_burst_sequencer #(
    parameter int MAX_BURST_LINES = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LEN_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 memcpy_enable,
    input  logic [63:0]          source_address,
    input  logic [63:0]          target_address,
    input  logic [63:0]          total_number,
    output logic                 memcpy_done,
    output logic                 busy,
    output logic                 rd_cmd_valid,
    input  logic                 rd_cmd_ready,
    output logic [63:0]          rd_cmd_addr,
    output logic [LEN_WIDTH-1:0] rd_cmd_lines,
    output logic                 wr_cmd_valid,
    input  logic                 wr_cmd_ready,
    output logic [63:0]          wr_cmd_addr,
    output logic [LEN_WIDTH-1:0] wr_cmd_lines,
    input  logic                 wr_done_valid
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_RD    = 3'd2,
        ST_WR    = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    localparam logic [63:0]          MAX_LINES64 = 64'(MAX_BURST_LINES);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN     = LEN_WIDTH'(MAX_BURST_LINES);
    localparam logic [3:0]           MAX_OUT     = 4'(MAX_OUTSTANDING);
    localparam logic [63:0]          LINE_MASK   = ~64'h3F;

    state_e               state_q, state_d;
    logic [63:0]          src_q, src_d;
    logic [63:0]          dst_q, dst_d;
    logic [63:0]          rem_q, rem_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [3:0]           outst_q, outst_d;
    logic                 abort_q, abort_d;

    logic                 wr_accept;
    logic                 done_dec;
    logic                 abort_now;
    logic [LEN_WIDTH-1:0] burst_len;
    logic [63:0]          burst_bytes;

`ifdef MEMCPY_4K_BOUNDARY_EN
    logic [6:0] src_room;
    logic [6:0] dst_room;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            outst_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            outst_q <= outst_d;
            abort_q <= abort_d;
        end
    end

    // Next burst length: remaining lines capped by the burst limit (and page room when enabled).
    always_comb begin
        burst_len = (rem_q < MAX_LINES64) ? rem_q[LEN_WIDTH-1:0] : MAX_LEN;
`ifdef MEMCPY_4K_BOUNDARY_EN
        src_room = 7'd64 - {1'b0, src_q[11:6]};
        dst_room = 7'd64 - {1'b0, dst_q[11:6]};
        if (int'(src_room) < int'(burst_len)) burst_len = LEN_WIDTH'(src_room);
        if (int'(dst_room) < int'(burst_len)) burst_len = LEN_WIDTH'(dst_room);
`endif
    end

    assign burst_bytes = 64'(len_q) << 6;
    assign wr_accept   = (state_q == ST_WR) && wr_cmd_ready;
    assign done_dec    = wr_done_valid && (outst_q != 4'd0);
    assign abort_now   = abort_q || !memcpy_enable;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        len_d   = len_q;
        abort_d = abort_q;
        outst_d = outst_q;

        // Simultaneous acceptance and completion cancel out.
        if (wr_accept && !done_dec) begin
            outst_d = outst_q + 4'd1;
        end else if (!wr_accept && done_dec) begin
            outst_d = outst_q - 4'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (memcpy_enable) begin
                    src_d   = source_address & LINE_MASK;
                    dst_d   = target_address & LINE_MASK;
                    rem_d   = total_number;
                    abort_d = 1'b0;
                    state_d = (total_number == 64'd0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                abort_d = abort_now;
                if (abort_now) begin
                    state_d = ST_DRAIN;
                end else begin
                    len_d   = burst_len;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                abort_d = abort_now;
                if (rd_cmd_ready) state_d = ST_WR;
            end
            ST_WR: begin
                abort_d = abort_now;
                if (wr_cmd_ready) begin
                    src_d = src_q + burst_bytes;
                    dst_d = dst_q + burst_bytes;
                    rem_d = rem_q - 64'(len_q);
                    if (abort_now || (rem_d == 64'd0)) begin
                        state_d = ST_DRAIN;
                    end else if (outst_d == MAX_OUT) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_HOLD: begin
                abort_d = abort_now;
                if (abort_now) begin
                    state_d = ST_DRAIN;
                end else if (outst_d < MAX_OUT) begin
                    state_d = ST_CALC;
                end
            end
            ST_DRAIN: begin
                if (outst_d == 4'd0) state_d = abort_q ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (!memcpy_enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign memcpy_done  = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign rd_cmd_valid = (state_q == ST_RD);
    assign wr_cmd_valid = (state_q == ST_WR);
    assign rd_cmd_addr  = src_q;
    assign rd_cmd_lines = len_q;
    assign wr_cmd_addr  = dst_q;
    assign wr_cmd_lines = len_q;

endmodule
